// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N producer streams in, one registered stream out.
// The slave modport is the arbiter's view, the master modport is the surrounding system's.
interface rr_arb_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                       MODE;
    logic [CHANNELS*WIDTH-1:0]  IN_DATA;
    logic [CHANNELS-1:0]        IN_VALID;
    logic [CHANNELS-1:0]        IN_READY;
    logic [WIDTH-1:0]           OUT_DATA;
    logic [SELW-1:0]            OUT_SEL;
    logic                       OUT_VALID;
    logic                       OUT_READY;

    modport slave (
        input  MODE, IN_DATA, IN_VALID, OUT_READY,
        output IN_READY, OUT_DATA, OUT_SEL, OUT_VALID
    );

    modport master (
        output MODE, IN_DATA, IN_VALID, OUT_READY,
        input  IN_READY, OUT_DATA, OUT_SEL, OUT_VALID
    );
endinterface

// File: rtl/rr_arb_mux.sv
// Arbitrating N:1 multiplexer with a single-entry registered output stage.
// MODE=0 selects round-robin starting at ptr_q, MODE=1 selects the lowest valid index.
module rr_arb_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    rr_arb_mux_if.slave bus
);
    localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_sel_q;
    logic             out_valid_q;
    logic [SELW-1:0]  ptr_q;

    logic             load_en;
    logic             grant_valid;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;
    int               idx;

    // The output stage may take a new word when empty or when it drains this cycle.
    assign load_en = !out_valid_q || bus.OUT_READY;
    assign xfer    = RST_N && load_en && grant_valid;

    // Grant search: start at ptr_q (round-robin) or 0 (fixed), wrap at CHANNELS.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        idx         = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = bus.MODE ? k : int'(ptr_q) + k;
            // ptr_q < CHANNELS and k < CHANNELS, so one subtraction always wraps into range.
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!grant_valid && bus.IN_VALID[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SELW'(idx);
                grant_data  = bus.IN_DATA[idx*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready toward the winning producer; held low during reset and stalls.
    always_comb begin
        bus.IN_READY = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.IN_READY[i] = xfer && (grant_idx == SELW'(i));
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!RST_N) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else if (xfer) begin
            out_data_q  <= grant_data;
            out_sel_q   <= grant_idx;
            out_valid_q <= 1'b1;
            if (!bus.MODE) begin
                if (grant_idx == SELW'(CHANNELS - 1)) ptr_q <= '0;
                else                                  ptr_q <= grant_idx + 1'b1;
            end
        end else if (load_en) begin
            // Drained with nothing to replace it: data and index keep their last values.
            out_valid_q <= 1'b0;
        end
    end

    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_SEL   = out_sel_q;
    assign bus.OUT_VALID = out_valid_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel instance for the main scenarios and a
// 3-channel instance for pointer wrap with a non-power-of-two channel count.
module tb_rr_arb_mux;
    logic CLK;
    logic RST_N;
    int   errors = 0;
    int   checks = 0;

    rr_arb_mux_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
    rr_arb_mux_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

    rr_arb_mux #(.WIDTH(8), .CHANNELS(4)) dut4 (.CLK(CLK), .RST_N(RST_N), .bus(bus4.slave));
    rr_arb_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (.CLK(CLK), .RST_N(RST_N), .bus(bus3.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N          = 1'b0;
        bus4.MODE      = 1'b0;
        bus4.OUT_READY = 1'b1;
        bus4.IN_VALID  = 4'b1111;
        for (int i = 0; i < 4; i++) bus4.IN_DATA[i*8 +: 8] = 8'hA0 + 8'(i);
        bus3.MODE      = 1'b0;
        bus3.OUT_READY = 1'b1;
        bus3.IN_VALID  = 3'b000;
        for (int i = 0; i < 3; i++) bus3.IN_DATA[i*8 +: 8] = 8'h30 + 8'(i);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus4.IN_READY !== 4'b0000 || bus4.OUT_VALID !== 1'b0) begin
                $display("FAIL reset_hold cyc%0d: in_ready=%b out_valid=%b, want 0000/0", c, bus4.IN_READY, bus4.OUT_VALID);
                errors++;
            end
        end
        checks++;
        if (bus4.OUT_DATA !== 8'h00 || bus4.OUT_SEL !== 2'd0 || dut4.ptr_q !== 2'd0) begin
            $display("FAIL reset_values: data=%h sel=%0d ptr=%0d, want 00/0/0", bus4.OUT_DATA, bus4.OUT_SEL, dut4.ptr_q);
            errors++;
        end
        RST_N = 1'b1;
        #1;
        checks++;
        if (bus4.IN_READY !== 4'b0001) begin
            $display("FAIL reset_first_grant: in_ready=%b, want 0001", bus4.IN_READY);
            errors++;
        end
        tick();
        checks++;
        if (bus4.OUT_VALID !== 1'b1 || bus4.OUT_SEL !== 2'd0 || bus4.OUT_DATA !== 8'hA0 || dut4.ptr_q !== 2'd1) begin
            $display("FAIL reset_first_xfer: valid=%b sel=%0d data=%h ptr=%0d, want 1/0/a0/1",
                     bus4.OUT_VALID, bus4.OUT_SEL, bus4.OUT_DATA, dut4.ptr_q);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel;
        for (int c = 0; c < 5; c++) begin
            exp_sel = 2'((c + 1) % 4);
            tick();
            checks++;
            if (bus4.OUT_VALID !== 1'b1 || bus4.OUT_SEL !== exp_sel || bus4.OUT_DATA !== (8'hA0 + 8'(exp_sel))) begin
                $display("FAIL rr_seq cyc%0d: valid=%b sel=%0d data=%h, want 1/%0d/%h",
                         c, bus4.OUT_VALID, bus4.OUT_SEL, bus4.OUT_DATA, exp_sel, 8'hA0 + 8'(exp_sel));
                errors++;
            end
        end
    endtask

    task automatic test_fixed_priority();
        bus4.MODE     = 1'b1;
        bus4.IN_VALID = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus4.OUT_SEL !== 2'd1 || bus4.OUT_DATA !== 8'hA1 || dut4.ptr_q !== 2'd2) begin
                $display("FAIL fixed_win cyc%0d: sel=%0d data=%h ptr=%0d, want 1/a1/2", c, bus4.OUT_SEL, bus4.OUT_DATA, dut4.ptr_q);
                errors++;
            end
        end
        bus4.IN_VALID = 4'b1000;
        tick();
        checks++;
        if (bus4.OUT_SEL !== 2'd3 || bus4.OUT_DATA !== 8'hA3 || dut4.ptr_q !== 2'd2) begin
            $display("FAIL fixed_ch3: sel=%0d data=%h ptr=%0d, want 3/a3/2", bus4.OUT_SEL, bus4.OUT_DATA, dut4.ptr_q);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        bus4.MODE            = 1'b0;
        bus4.IN_VALID        = 4'b0100;
        bus4.IN_DATA[16 +: 8] = 8'h5C;
        tick();
        checks++;
        if (bus4.OUT_SEL !== 2'd2 || bus4.OUT_DATA !== 8'h5C || dut4.ptr_q !== 2'd3) begin
            $display("FAIL bp_load: sel=%0d data=%h ptr=%0d, want 2/5c/3", bus4.OUT_SEL, bus4.OUT_DATA, dut4.ptr_q);
            errors++;
        end
        bus4.OUT_READY = 1'b0;
        bus4.IN_VALID  = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus4.IN_READY !== 4'b0000) begin
                $display("FAIL bp_ready cyc%0d: in_ready=%b, want 0000", c, bus4.IN_READY);
                errors++;
            end
            tick();
            checks++;
            if (bus4.OUT_VALID !== 1'b1 || bus4.OUT_SEL !== 2'd2 || bus4.OUT_DATA !== 8'h5C || dut4.ptr_q !== 2'd3) begin
                $display("FAIL bp_hold cyc%0d: valid=%b sel=%0d data=%h ptr=%0d, want 1/2/5c/3",
                         c, bus4.OUT_VALID, bus4.OUT_SEL, bus4.OUT_DATA, dut4.ptr_q);
                errors++;
            end
        end
        bus4.OUT_READY = 1'b1;
        #1;
        checks++;
        if (bus4.IN_READY !== 4'b1000) begin
            $display("FAIL bp_release_grant: in_ready=%b, want 1000", bus4.IN_READY);
            errors++;
        end
        tick();
        checks++;
        if (bus4.OUT_SEL !== 2'd3 || bus4.OUT_DATA !== 8'hA3 || dut4.ptr_q !== 2'd0) begin
            $display("FAIL bp_release_xfer: sel=%0d data=%h ptr=%0d, want 3/a3/0", bus4.OUT_SEL, bus4.OUT_DATA, dut4.ptr_q);
            errors++;
        end
    endtask

    task automatic test_drain();
        bus4.IN_VALID = 4'b0000;
        tick();
        checks++;
        if (bus4.OUT_VALID !== 1'b0 || bus4.OUT_SEL !== 2'd3 || bus4.OUT_DATA !== 8'hA3) begin
            $display("FAIL drain: valid=%b sel=%0d data=%h, want 0/3/a3", bus4.OUT_VALID, bus4.OUT_SEL, bus4.OUT_DATA);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_sel [3];
        exp_sel[0] = 2'd1;
        exp_sel[1] = 2'd2;
        exp_sel[2] = 2'd1;
        bus4.IN_VALID = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus4.OUT_VALID !== 1'b1 || bus4.OUT_SEL !== exp_sel[c]) begin
                $display("FAIL b2b_sparse cyc%0d: valid=%b sel=%0d, want 1/%0d", c, bus4.OUT_VALID, bus4.OUT_SEL, exp_sel[c]);
                errors++;
            end
        end
    endtask

    task automatic test_mid_reset();
        bus4.OUT_READY = 1'b0;
        bus4.IN_VALID  = 4'b1111;
        tick();
        RST_N = 1'b0;
        #1;
        checks++;
        if (bus4.IN_READY !== 4'b0000 || bus4.OUT_VALID !== 1'b1) begin
            $display("FAIL midrst_pre: in_ready=%b valid=%b, want 0000/1", bus4.IN_READY, bus4.OUT_VALID);
            errors++;
        end
        tick();
        checks++;
        if (bus4.OUT_VALID !== 1'b0 || bus4.OUT_DATA !== 8'h00 || bus4.OUT_SEL !== 2'd0 || dut4.ptr_q !== 2'd0) begin
            $display("FAIL midrst_clear: valid=%b data=%h sel=%0d ptr=%0d, want 0/00/0/0",
                     bus4.OUT_VALID, bus4.OUT_DATA, bus4.OUT_SEL, dut4.ptr_q);
            errors++;
        end
        RST_N          = 1'b1;
        bus4.OUT_READY = 1'b1;
        tick();
        checks++;
        if (bus4.OUT_VALID !== 1'b1 || bus4.OUT_SEL !== 2'd0 || bus4.OUT_DATA !== 8'hA0) begin
            $display("FAIL midrst_restart: valid=%b sel=%0d data=%h, want 1/0/a0", bus4.OUT_VALID, bus4.OUT_SEL, bus4.OUT_DATA);
            errors++;
        end
    endtask

    task automatic test_wrap_npot();
        bus3.IN_VALID = 3'b010;
        tick();
        checks++;
        if (bus3.OUT_SEL !== 2'd1 || dut3.ptr_q !== 2'd2) begin
            $display("FAIL wrap_setup: sel=%0d ptr=%0d, want 1/2", bus3.OUT_SEL, dut3.ptr_q);
            errors++;
        end
        bus3.IN_VALID = 3'b001;
        #1;
        checks++;
        if (bus3.IN_READY !== 3'b001) begin
            $display("FAIL wrap_grant0: in_ready=%b, want 001", bus3.IN_READY);
            errors++;
        end
        tick();
        checks++;
        if (bus3.OUT_SEL !== 2'd0 || bus3.OUT_DATA !== 8'h30 || dut3.ptr_q !== 2'd1) begin
            $display("FAIL wrap_ch0: sel=%0d data=%h ptr=%0d, want 0/30/1", bus3.OUT_SEL, bus3.OUT_DATA, dut3.ptr_q);
            errors++;
        end
        bus3.IN_VALID = 3'b100;
        tick();
        checks++;
        if (bus3.OUT_SEL !== 2'd2 || bus3.OUT_DATA !== 8'h32 || dut3.ptr_q !== 2'd0) begin
            $display("FAIL wrap_ch2: sel=%0d data=%h ptr=%0d, want 2/32/0", bus3.OUT_SEL, bus3.OUT_DATA, dut3.ptr_q);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_drain();
        test_back_to_back();
        test_mid_reset();
        test_wrap_npot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
